// File: rtl/bank_arb_pkg.sv
// bank_arb_pkg: shared owner encodings and the address-window helper used
// by the dual-port bank arbiter and its grant logic.
package bank_arb_pkg;

    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    // Addresses are zero-extended to 32 bits by the caller.
    // Two separate unsigned compares.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] lo,
                                       input logic [31:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/bank_arb_grant.sv
// bank_arb_grant: combinational grant selection for the two requesters.
//   i_elig_a / i_elig_b : requester is valid and inside the bank window
//   i_rr_last           : last conflict winner (only with BANK_ARB_RR_EN)
//   o_gnt_a / o_gnt_b   : one-hot (or zero) grant
// Macro BANK_ARB_RR_EN: alternate the winner on conflicts; otherwise A > B.
module bank_arb_grant
    import bank_arb_pkg::*;
(
    input  logic i_elig_a,
    input  logic i_elig_b,
`ifdef BANK_ARB_RR_EN
    input  logic i_rr_last,
`endif
    output logic o_gnt_a,
    output logic o_gnt_b
);

    always_comb begin
        o_gnt_a = i_elig_a;
        o_gnt_b = i_elig_b & ~i_elig_a;
`ifdef BANK_ARB_RR_EN
        // On a conflict the requester that did not win last time goes first.
        if (i_elig_a & i_elig_b) begin
            o_gnt_a = (i_rr_last == OWNER_B);
            o_gnt_b = (i_rr_last == OWNER_A);
        end
`endif
    end

endmodule

// File: rtl/bank_arbiter_dual.sv
// bank_arbiter_dual: two-requester arbiter in front of one single-port BRAM
// bank owning [LOWER_ADDR, UPPER_ADDR].
//   clk, rst                 : clock, synchronous active-high reset
//   a_* / b_*                : requester valid/ready request, rvalid/rdata reply
//   mem_en/we/addr/wdata     : registered BRAM port
//   mem_rdata                : BRAM read data, one cycle after a read enable
//   conflict, conflict_cnt   : both eligible last cycle, saturating count
// Macro BANK_ARB_RR_EN: round-robin on conflict (first conflict goes to A).
module bank_arbiter_dual
    import bank_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32,
    parameter int LOWER_ADDR = 0,
    parameter int UPPER_ADDR = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic                  a_we,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_ready,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_valid,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic                  b_we,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_ready,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  conflict,
    output logic [CNT_WIDTH-1:0]  conflict_cnt
);

    logic                  w_elig_a, w_elig_b, w_gnt_a, w_gnt_b;
    logic                  w_hs, w_conf, w_sel_we, w_sel_owner;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;

    logic                  r_mem_en, r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_rd_pend, r_rd_owner;   // stage-1 read tag
    logic                  r_rsp_vld, r_rsp_owner;  // stage-2 response tag
    logic                  r_conflict;
    logic [CNT_WIDTH-1:0]  r_cnt;
`ifdef BANK_ARB_RR_EN
    logic                  r_rr_last;
`endif

    // Eligibility is masked during reset so ready stays low and nothing
    // is counted while the block is held in reset.
    assign w_elig_a = a_valid & ~rst &
                      in_window(32'(a_addr), 32'(LOWER_ADDR), 32'(UPPER_ADDR));
    assign w_elig_b = b_valid & ~rst &
                      in_window(32'(b_addr), 32'(LOWER_ADDR), 32'(UPPER_ADDR));
    assign w_conf   = w_elig_a & w_elig_b;

    bank_arb_grant u_grant (
        .i_elig_a  (w_elig_a),
        .i_elig_b  (w_elig_b),
`ifdef BANK_ARB_RR_EN
        .i_rr_last (r_rr_last),
`endif
        .o_gnt_a   (w_gnt_a),
        .o_gnt_b   (w_gnt_b)
    );

    assign w_hs        = w_gnt_a | w_gnt_b;
    assign w_sel_we    = w_gnt_b ? b_we    : a_we;
    assign w_sel_addr  = w_gnt_b ? b_addr  : a_addr;
    assign w_sel_wdata = w_gnt_b ? b_wdata : a_wdata;
    assign w_sel_owner = w_gnt_b ? OWNER_B : OWNER_A;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rd_pend   <= 1'b0;
            r_rd_owner  <= OWNER_A;
            r_rsp_vld   <= 1'b0;
            r_rsp_owner <= OWNER_A;
            r_conflict  <= 1'b0;
            r_cnt       <= '0;
`ifdef BANK_ARB_RR_EN
            r_rr_last   <= OWNER_B;
`endif
        end else begin
            r_mem_en <= w_hs;
            r_mem_we <= w_hs & w_sel_we;
            if (w_hs) begin
                r_mem_addr  <= w_sel_addr;
                r_mem_wdata <= w_sel_wdata;
            end
            r_rd_pend   <= w_hs & ~w_sel_we;
            r_rd_owner  <= w_sel_owner;
            // BRAM data appears the cycle after the read enable.
            r_rsp_vld   <= r_rd_pend;
            r_rsp_owner <= r_rd_owner;
            r_conflict  <= w_conf;
            if (w_conf && (r_cnt != '1))
                r_cnt <= r_cnt + CNT_WIDTH'(1);
`ifdef BANK_ARB_RR_EN
            if (w_conf)
                r_rr_last <= w_sel_owner;
`endif
        end
    end

    assign a_ready      = w_gnt_a;
    assign b_ready      = w_gnt_b;
    assign a_rvalid     = r_rsp_vld & (r_rsp_owner == OWNER_A);
    assign b_rvalid     = r_rsp_vld & (r_rsp_owner == OWNER_B);
    assign a_rdata      = a_rvalid ? mem_rdata : '0;
    assign b_rdata      = b_rvalid ? mem_rdata : '0;
    assign mem_en       = r_mem_en;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign conflict     = r_conflict;
    assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_bank_arbiter_dual.sv
module tb_bank_arbiter_dual;
    import bank_arb_pkg::*;

    localparam int AW = 13;
    localparam int DW = 32;
    localparam int LO = 0;
    localparam int HI = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_valid = 1'b0, a_we = 1'b0, b_valid = 1'b0, b_we = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;
    logic          a_ready, a_rvalid, b_ready, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          mem_en, mem_we, conflict;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [15:0]   conflict_cnt;

    // Second instance with a 4-bit counter for the saturation case.
    logic          s_a_ready, s_a_rvalid, s_b_ready, s_b_rvalid;
    logic [DW-1:0] s_a_rdata, s_b_rdata, s_mem_wdata;
    logic          s_mem_en, s_mem_we, s_conflict;
    logic [AW-1:0] s_mem_addr;
    logic [3:0]    s_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bank_arbiter_dual #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOWER_ADDR(LO),
                        .UPPER_ADDR(HI), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_we(a_we), .a_wdata(a_wdata),
        .a_ready(a_ready), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_valid(b_valid), .b_addr(b_addr), .b_we(b_we), .b_wdata(b_wdata),
        .b_ready(b_ready), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .conflict(conflict), .conflict_cnt(conflict_cnt));

    bank_arbiter_dual #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOWER_ADDR(LO),
                        .UPPER_ADDR(HI), .CNT_WIDTH(4)) u_sat (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_we(a_we), .a_wdata(a_wdata),
        .a_ready(s_a_ready), .a_rvalid(s_a_rvalid), .a_rdata(s_a_rdata),
        .b_valid(b_valid), .b_addr(b_addr), .b_we(b_we), .b_wdata(b_wdata),
        .b_ready(s_b_ready), .b_rvalid(s_b_rvalid), .b_rdata(s_b_rdata),
        .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
        .mem_wdata(s_mem_wdata), .mem_rdata(mem_rdata),
        .conflict(s_conflict), .conflict_cnt(s_cnt));

    // BRAM behind the main instance.
    logic [DW-1:0] bram    [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) bram[mem_addr] <= mem_wdata;
            else        mem_rdata      <= bram[mem_addr];
        end
    end

    // ---------------- reference model ----------------
    logic          m_mem_en = 1'b0, m_mem_we = 1'b0, m_conflict = 1'b0;
    logic [AW-1:0] m_mem_addr = '0;
    logic [DW-1:0] m_mem_wdata = '0;
    logic [15:0]   m_cnt = '0;
    logic [3:0]    m_cnt4 = '0;
    logic          m_last = OWNER_B;
    int            m_cyc = 0;
    int            m_due_cyc [4] = '{-1, -1, -1, -1};
    logic          m_due_own [4];
    logic [DW-1:0] m_due_dat [4];

    function automatic logic el_a();
        return a_valid && !rst && (int'(a_addr) >= LO) && (int'(a_addr) <= HI);
    endfunction
    function automatic logic el_b();
        return b_valid && !rst && (int'(b_addr) >= LO) && (int'(b_addr) <= HI);
    endfunction
    function automatic logic gnt_a();
        if (el_a() && el_b()) begin
`ifdef BANK_ARB_RR_EN
            return m_last == OWNER_B;
`else
            return 1'b1;
`endif
        end
        return el_a();
    endfunction
    function automatic logic gnt_b();
        if (el_a() && el_b()) begin
`ifdef BANK_ARB_RR_EN
            return m_last == OWNER_A;
`else
            return 1'b0;
`endif
        end
        return el_b();
    endfunction

    always @(posedge clk) begin
        m_cyc <= m_cyc + 1;
        if (rst) begin
            m_mem_en <= 1'b0; m_mem_we <= 1'b0; m_mem_addr <= '0; m_mem_wdata <= '0;
            m_conflict <= 1'b0; m_cnt <= '0; m_cnt4 <= '0; m_last <= OWNER_B;
            for (int i = 0; i < 4; i++) m_due_cyc[i] <= -1;
        end else begin
            m_conflict <= el_a() && el_b();
            if (el_a() && el_b()) begin
                if (m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
                if (m_cnt4 != 4'hF) m_cnt4 <= m_cnt4 + 4'd1;
                m_last <= gnt_b() ? OWNER_B : OWNER_A;
            end
            m_mem_en <= gnt_a() || gnt_b();
            m_mem_we <= (gnt_a() && a_we) || (gnt_b() && b_we);
            if (gnt_a()) begin
                m_mem_addr <= a_addr; m_mem_wdata <= a_wdata;
                if (a_we) ref_mem[a_addr] <= a_wdata;
                else begin
                    m_due_cyc[(m_cyc+2)%4] <= m_cyc + 2;
                    m_due_own[(m_cyc+2)%4] <= OWNER_A;
                    m_due_dat[(m_cyc+2)%4] <= ref_mem[a_addr];
                end
            end
            if (gnt_b()) begin
                m_mem_addr <= b_addr; m_mem_wdata <= b_wdata;
                if (b_we) ref_mem[b_addr] <= b_wdata;
                else begin
                    m_due_cyc[(m_cyc+2)%4] <= m_cyc + 2;
                    m_due_own[(m_cyc+2)%4] <= OWNER_B;
                    m_due_dat[(m_cyc+2)%4] <= ref_mem[b_addr];
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_valid = 1'b0; b_valid = 1'b0; a_we = 1'b0; b_we = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            a_valid = 1'b1; a_addr = 13'd1; b_valid = 1'b1; b_addr = 13'd2;
            @(negedge clk);
        end
        n_chk++;
        if ({a_ready, b_ready} !== 2'b00) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 00", {a_ready, b_ready});
        end
        n_chk++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
            n_fail++; $display("FAIL reset_mem: got en=%b we=%b addr=%0h wd=%0h expected all 0",
                               mem_en, mem_we, mem_addr, mem_wdata);
        end
        n_chk++;
        if ({a_rvalid, b_rvalid, a_rdata, b_rdata} !== '0) begin
            n_fail++; $display("FAIL reset_resp: got rv=%b%b rd=%0h/%0h expected all 0",
                               a_rvalid, b_rvalid, a_rdata, b_rdata);
        end
        n_chk++;
        if ({conflict, conflict_cnt, s_cnt} !== '0) begin
            n_fail++; $display("FAIL reset_conflict: got c=%b cnt=%0d sat=%0d expected 0",
                               conflict, conflict_cnt, s_cnt);
        end
        step(); rst = 1'b0; idle();
        @(negedge clk);
    endtask

    task automatic test_single_read();
        step(); a_valid = 1'b1; a_we = 1'b0; a_addr = 13'd2;
        @(negedge clk);
        n_chk++;
        if ({a_ready, b_ready} !== 2'b10) begin
            n_fail++; $display("FAIL single_ready: got %b expected 10", {a_ready, b_ready});
        end
        step(); idle();
        @(negedge clk);
        n_chk++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 13'd2}) begin
            n_fail++; $display("FAIL single_mem: got en=%b we=%b addr=%0d expected 1 0 2",
                               mem_en, mem_we, mem_addr);
        end
        step();
        @(negedge clk);
        n_chk++;
        if ({a_rvalid, a_rdata, b_rvalid} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
            n_fail++; $display("FAIL single_resp: got arv=%b ard=%0h brv=%b expected 1 deadbeef 0",
                               a_rvalid, a_rdata, b_rvalid);
        end
        step();
        @(negedge clk);
        n_chk++;
        if ({a_rvalid, b_rvalid} !== 2'b00) begin
            n_fail++; $display("FAIL single_pulse: got %b expected 00", {a_rvalid, b_rvalid});
        end
    endtask

    task automatic test_out_of_window();
        for (int i = 0; i < 5; i++) begin
            step(); b_valid = 1'b1; b_we = 1'b1; b_addr = 13'd7; b_wdata = 32'h55;
            @(negedge clk);
            n_chk++;
            if ({b_ready, mem_en} !== 2'b00) begin
                n_fail++; $display("FAIL oow_cycle%0d: got ready=%b en=%b expected 0 0",
                                   i, b_ready, mem_en);
            end
        end
        step(); idle();
        @(negedge clk);
        n_chk++;
        if ({mem_en, conflict_cnt} !== 17'd0) begin
            n_fail++; $display("FAIL oow_after: got en=%b cnt=%0d expected 0 0", mem_en, conflict_cnt);
        end
    endtask

    task automatic test_conflict_fixed();
        step();
        a_valid = 1'b1; a_we = 1'b1; a_addr = 13'd1; a_wdata = 32'h11;
        b_valid = 1'b1; b_we = 1'b0; b_addr = 13'd3;
        @(negedge clk);
        n_chk++;
        if ({a_ready, b_ready} !== 2'b10) begin
            n_fail++; $display("FAIL conf_grant: got %b expected 10", {a_ready, b_ready});
        end
        step(); a_valid = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({b_ready, conflict, conflict_cnt} !== {1'b1, 1'b1, 16'd1}) begin
            n_fail++; $display("FAIL conf_next: got bready=%b c=%b cnt=%0d expected 1 1 1",
                               b_ready, conflict, conflict_cnt);
        end
        n_chk++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 13'd1, 32'h11}) begin
            n_fail++; $display("FAIL conf_wr: got en=%b we=%b addr=%0d wd=%0h expected 1 1 1 11",
                               mem_en, mem_we, mem_addr, mem_wdata);
        end
        step(); idle();
        @(negedge clk);
        n_chk++;
        if ({conflict, mem_en, mem_we, mem_addr, b_rvalid} !== {1'b0, 1'b1, 1'b0, 13'd3, 1'b0}) begin
            n_fail++; $display("FAIL conf_rd: got c=%b en=%b we=%b addr=%0d brv=%b expected 0 1 0 3 0",
                               conflict, mem_en, mem_we, mem_addr, b_rvalid);
        end
        step();
        @(negedge clk);
        n_chk++;
        if ({b_rvalid, b_rdata, a_rvalid, a_rdata} !== {1'b1, 32'hCAFE0003, 1'b0, 32'h0}) begin
            n_fail++; $display("FAIL conf_resp: got brv=%b brd=%0h arv=%b ard=%0h expected 1 cafe0003 0 0",
                               b_rvalid, b_rdata, a_rvalid, a_rdata);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp;
        step(); rst = 1'b1; idle();
        step(); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            a_valid = 1'b1; a_we = 1'b1; a_addr = 13'd0; a_wdata = 32'hA0;
            b_valid = 1'b1; b_we = 1'b1; b_addr = 13'd4; b_wdata = 32'hB4;
            @(negedge clk);
`ifdef BANK_ARB_RR_EN
            exp = (i % 2 == 0) ? 2'b10 : 2'b01;
`else
            exp = 2'b10;
`endif
            n_chk++;
            if ({a_ready, b_ready} !== exp) begin
                n_fail++; $display("FAIL rr_grant%0d: got %b expected %b", i, {a_ready, b_ready}, exp);
            end
        end
        step(); idle();
        @(negedge clk);
        n_chk++;
        if (conflict_cnt !== 16'd4) begin
            n_fail++; $display("FAIL rr_cnt: got %0d expected 4", conflict_cnt);
        end
    endtask

    task automatic test_reset_mid_read();
        step(); a_valid = 1'b1; a_we = 1'b0; a_addr = 13'd2;
        @(negedge clk);
        n_chk++;
        if (a_ready !== 1'b1) begin
            n_fail++; $display("FAIL midrst_hs: got %b expected 1", a_ready);
        end
        step(); rst = 1'b1; a_addr = 13'd0;
        @(negedge clk);
        n_chk++;
        if (a_ready !== 1'b0) begin
            n_fail++; $display("FAIL midrst_ready: got %b expected 0", a_ready);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            @(negedge clk);
            n_chk++;
            if ({a_ready, b_ready, a_rvalid, b_rvalid, a_rdata, b_rdata, mem_en, mem_we,
                 mem_addr, mem_wdata, conflict, conflict_cnt} !== '0) begin
                n_fail++; $display("FAIL midrst_out%0d: got arv=%b en=%b addr=%0d cnt=%0d expected all 0",
                                   i, a_rvalid, mem_en, mem_addr, conflict_cnt);
            end
        end
        step(); rst = 1'b0; idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++;
            if (a_rvalid !== 1'b0) begin
                n_fail++; $display("FAIL midrst_after%0d: got %b expected 0", i, a_rvalid);
            end
            step();
        end
    endtask

    task automatic test_saturation();
        step(); rst = 1'b1; idle();
        step(); rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            a_valid = 1'b1; a_we = 1'b1; a_addr = 13'd2; a_wdata = 32'h77;
            b_valid = 1'b1; b_we = 1'b1; b_addr = 13'd3; b_wdata = 32'h88;
            @(negedge clk);
            n_chk++;
            if (s_cnt !== m_cnt4) begin
                n_fail++; $display("FAIL sat_cnt%0d: got %0d expected %0d", i, s_cnt, m_cnt4);
            end
        end
        step(); idle();
        @(negedge clk);
        n_chk++;
        if ({s_cnt, conflict_cnt} !== {4'hF, 16'd20}) begin
            n_fail++; $display("FAIL sat_final: got sat=%0d wide=%0d expected 15 20", s_cnt, conflict_cnt);
        end
    endtask

    task automatic test_random();
        logic          acc_a = 1'b1, acc_b = 1'b1, hit, erv_a, erv_b;
        logic [DW-1:0] erd_a, erd_b;
        int            k;
        for (int n = 0; n < 400; n++) begin
            step();
            if (acc_a || !a_valid || int'(a_addr) > HI) begin
                a_valid = ($urandom_range(0, 3) != 0); a_addr = AW'($urandom_range(0, 6));
                a_we = 1'($urandom_range(0, 1)); a_wdata = $urandom;
            end
            if (acc_b || !b_valid || int'(b_addr) > HI) begin
                b_valid = ($urandom_range(0, 3) != 0); b_addr = AW'($urandom_range(0, 6));
                b_we = 1'($urandom_range(0, 1)); b_wdata = $urandom;
            end
            @(negedge clk);
            acc_a = a_ready; acc_b = b_ready;
            k = m_cyc % 4;
            hit = (m_due_cyc[k] == m_cyc);
            erv_a = hit && (m_due_own[k] == OWNER_A);
            erv_b = hit && (m_due_own[k] == OWNER_B);
            erd_a = erv_a ? m_due_dat[k] : '0;
            erd_b = erv_b ? m_due_dat[k] : '0;
            n_chk++;
            if ({a_ready, b_ready} !== {gnt_a(), gnt_b()}) begin
                n_fail++; $display("FAIL rnd_ready%0d: got %b expected %b", n, {a_ready, b_ready}, {gnt_a(), gnt_b()});
            end
            n_chk++;
            if ({mem_en, mem_we, mem_addr, mem_wdata} !== {m_mem_en, m_mem_we, m_mem_addr, m_mem_wdata}) begin
                n_fail++; $display("FAIL rnd_mem%0d: got %b %b %0h %0h expected %b %b %0h %0h", n,
                                   mem_en, mem_we, mem_addr, mem_wdata, m_mem_en, m_mem_we, m_mem_addr, m_mem_wdata);
            end
            n_chk++;
            if ({a_rvalid, a_rdata, b_rvalid, b_rdata} !== {erv_a, erd_a, erv_b, erd_b}) begin
                n_fail++; $display("FAIL rnd_resp%0d: got %b %0h %b %0h expected %b %0h %b %0h", n,
                                   a_rvalid, a_rdata, b_rvalid, b_rdata, erv_a, erd_a, erv_b, erd_b);
            end
            n_chk++;
            if ({conflict, conflict_cnt} !== {m_conflict, m_cnt}) begin
                n_fail++; $display("FAIL rnd_conf%0d: got %b %0d expected %b %0d", n,
                                   conflict, conflict_cnt, m_conflict, m_cnt);
            end
        end
        step(); idle();
    endtask

    initial begin
        logic [DW-1:0] v;
        for (int i = 0; i < 8; i++) begin
            v = $urandom;
            bram[i] <= v; ref_mem[i] <= v;
        end
        bram[2] <= 32'hDEADBEEF; ref_mem[2] <= 32'hDEADBEEF;
        bram[3] <= 32'hCAFE0003; ref_mem[3] <= 32'hCAFE0003;
        test_reset();
        test_single_read();
        test_out_of_window();
        test_conflict_fixed();
        test_round_robin();
        test_reset_mid_read();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bank_arbiter_dual.md
Name: bank_arbiter_dual

Overview:
- Two-port arbiter in front of one single-port BRAM bank of the diffusion/random-walk datapath. The bank owns the address window [LOWER_ADDR, UPPER_ADDR].
- Two M-module requesters (A, B) present read/write requests with valid/ready handshakes.
- Per cycle, the arbiter grants at most one in-window request, drives the bank port from registers, and routes read data back to the owning requester with a response strobe.
- It replaces tri-state muxing with explicit, registered grant sequencing and counts conflicts.

Parameters:
- ADDR_WIDTH, 13, width of requester and BRAM addresses.
- DATA_WIDTH, 32, data width.
- LOWER_ADDR, 0, lowest address owned by this bank (inclusive).
- UPPER_ADDR, 4, highest address owned by this bank (inclusive); must satisfy UPPER_ADDR >= LOWER_ADDR.
- CNT_WIDTH, 16, width of the conflict counter.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- a_valid  in  1  requester A request valid.
- a_addr  in  ADDR_WIDTH  requester A address.
- a_we  in  1  1=write, 0=read.
- a_wdata  in  DATA_WIDTH  requester A write data.
- a_ready  out  1  A request accepted this cycle (combinational).
- a_rvalid  out  1  A read data valid, one-cycle pulse.
- a_rdata  out  DATA_WIDTH  A read data.
- b_valid, b_addr, b_we, b_wdata, b_ready, b_rvalid, b_rdata: same as A, for requester B.
- mem_en  out  1  BRAM enable (registered).
- mem_we  out  1  BRAM write enable (registered).
- mem_addr  out  ADDR_WIDTH  BRAM address (registered).
- mem_wdata  out  DATA_WIDTH  BRAM write data (registered).
- mem_rdata  in  DATA_WIDTH  BRAM read data, valid 1 cycle after mem_en with mem_we=0.
- conflict  out  1  registered pulse: both requesters competed in the previous cycle.
- conflict_cnt  out  CNT_WIDTH  saturating count of conflict cycles.

Behaviour:
- In-window test: (addr >= LOWER_ADDR) && (addr <= UPPER_ADDR), as two separate unsigned compares.
- Eligible: valid && in-window. Out-of-window requests are never granted, ready stays 0, and they do not affect priority or counters.
- Grant (combinational):
  - Only one eligible requester: it wins.
  - Both eligible: fixed priority, A wins.
  - x_ready = granted.
  - The handshake completes when valid && ready. The requester must hold its request stable until ready.
- Stage 1 (registered on handshake):
  - mem_en=1, mem_we=x_we, mem_addr=x_addr, mem_wdata=x_wdata.
  - A 2-state pending-read tag records {read_pending, owner}.
  - With no handshake: mem_en=0, mem_we=0; addr/wdata hold.
- Stage 2: the cycle after mem_en with mem_we=0, x_rvalid pulses for the tagged owner and x_rdata is mem_rdata. Read latency from handshake to rvalid is 2 cycles.
- Writes produce no response.
- Throughput: one access per cycle; back-to-back reads from alternating owners are permitted.
- Unselected x_rdata is driven 0; no Z on any output.
- Conflict: both eligible in the same cycle. The next cycle, conflict=1 and conflict_cnt increments, saturating at all-ones.
- Reset: all outputs 0, the pending tag is cleared, and the round-robin pointer points to A.
- Reset mid-operation: an in-flight read is dropped and no rvalid is issued after reset.
- Simultaneous read and write to the same address from A and B: serialized in grant order. The BRAM read-during-write behaviour is not the arbiter's concern.

Optional Feature:
- Macro: BANK_ARB_RR_EN.
- Defined: round-robin on conflict.
  - A 1-bit last-winner register holds the last conflict winner; on the next conflict the other requester wins.
  - It updates only on conflict cycles.
  - Reset value: B, so A wins the first conflict.
- Undefined: fixed priority, A > B. The pointer register is not generated.

Decomposition:
- Package bank_arb_pkg:
  - localparam OWNER_A=1'b0, OWNER_B=1'b1.
  - A function in_window(addr, lo, hi).
- One natural sub-module: bank_arb_grant. It is combinational grant logic with eligibility in, grant out, and an optional RR pointer input.
- Datapath registers and the response tag stay in the top module.

Test Plan:
- Single read: A read at addr 2 with BRAM word 0xDEADBEEF → a_ready=1 in the same cycle, mem_en=1 with mem_addr=2 next cycle, a_rvalid=1 with a_rdata=0xDEADBEEF two cycles after the handshake; b_rvalid stays 0.
- Out-of-window: B write at addr 7 (window 0..4) held for 5 cycles → b_ready=0, mem_en=0 throughout, conflict_cnt=0.
- Conflict, fixed priority: A write 0x11 at addr 1 and B read at addr 3 in the same cycle → A granted, conflict=1 next cycle, conflict_cnt=1; B granted the following cycle and receives b_rvalid 2 cycles after its handshake.
- Conflict, BANK_ARB_RR_EN defined: both continuously eligible for 4 cycles → grants A,B,A,B; conflict_cnt=4.
- Reset mid-read: A read handshake, rst=1 on the next edge → a_rvalid never asserts; all outputs 0 during reset.
- Saturation: CNT_WIDTH=4, 20 consecutive conflict cycles → conflict_cnt holds at 15.
